imem_port_arbiter: RTL

//  Sequences and shares the byte-wide, big-endian instruction memory between two requesters.
//   - Fetch: the PC path reads 32-bit words.
//   - Loader: program download / debug writes 32-bit words.

---
 rtl/imem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Shares a byte-wide big-endian instruction memory between a fetch reader and a loader writer.
// Each 32-bit word moves as four MSB-first byte beats; bad addresses complete without memory access.
//
// state | meaning
// IDLE  | no transfer; arbitrate pending requests
// BEAT  | byte beat b = 0..3 on the memory port
// DONE  | one-cycle completion pulse for the granted requester
module imem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_done,
   output logic [31:0]       fetch_inst,
   output logic              fetch_err,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

   // One extra bit keeps the range compare from wrapping near the top of the address space.
   localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W+1)'(MEM_BYTES - 4);

   state_t            state, state_nxt;
   logic [1:0]        b;
   logic              last_load;
   logic              cur_load;
   logic              err_q;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       wdata_q;
   logic [31:0]       shadow_q;

   logic              grant;
   logic              grant_load;
   logic [ADDR_W-1:0] grant_addr;
   logic              addr_err;

   always_comb begin
      grant      = (state == IDLE) && (fetch_req || load_req);
      grant_load = load_req && (!fetch_req || !last_load);
      grant_addr = grant_load ? load_addr : fetch_addr;
      addr_err   = (grant_addr[1:0] != 2'b00) || ({1'b0, grant_addr} > LAST_BASE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = addr_err ? DONE : BEAT;
         BEAT:    if (b == 2'd3) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wdata  = 8'h00;
      fetch_done = (state == DONE) && !cur_load;
      load_done  = (state == DONE) && cur_load;
      fetch_err  = fetch_done && err_q;
      load_err   = load_done && err_q;
      if (state == BEAT) begin
         mem_addr = base_q + ADDR_W'(b);
         mem_we   = cur_load;
         if (cur_load) begin
            case (b)
               2'd0:    mem_wdata = wdata_q[31:24];
               2'd1:    mem_wdata = wdata_q[23:16];
               2'd2:    mem_wdata = wdata_q[15:8];
               default: mem_wdata = wdata_q[7:0];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         b          <= 2'd0;
         last_load  <= 1'b1;
         cur_load   <= 1'b0;
         err_q      <= 1'b0;
         base_q     <= '0;
         wdata_q    <= 32'h0;
         shadow_q   <= 32'h0;
         fetch_inst <= 32'h0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            cur_load  <= grant_load;
            last_load <= grant_load;
            base_q    <= grant_addr;
            err_q     <= addr_err;
            b         <= 2'd0;
            if (grant_load) wdata_q <= load_data;
            if (!grant_load && addr_err) fetch_inst <= 32'h0;
         end
         if (state == BEAT) begin
            b <= b + 2'd1;
            if (!cur_load) begin
               case (b)
                  2'd0:    shadow_q[31:24] <= mem_rdata;
                  2'd1:    shadow_q[23:16] <= mem_rdata;
                  2'd2:    shadow_q[15:8]  <= mem_rdata;
                  default: shadow_q[7:0]   <= mem_rdata;
               endcase
               // Publish the full word on entry to DONE so it is valid alongside fetch_done.
               if (b == 2'd3) fetch_inst <= {shadow_q[31:8], mem_rdata};
            end
         end
      end
   end

endmodule
